imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32) and in_tag (input, TAG_W), forming the upstream handshake.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream handshake.
REQ-008 SHALL have port out_imm, output, XLEN, the generated immediate.
REQ-009 SHALL have port out_type, output, 3, immediate type: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved and never driven.
REQ-010 SHALL have ports out_tag (output, TAG_W), a copy of in_tag, and out_illegal (output, 1), unrecognised encoding.

Function
REQ-011 SHALL accept an input when in_valid && in_ready, and SHALL deliver an output when out_valid && out_ready.
REQ-012 SHALL present an accepted instruction on the outputs no earlier than the cycle after acceptance; with no backpressure, latency is exactly 1 cycle.
REQ-013 SHALL hold two entries (output register plus skid register); in_ready SHALL be registered and equal to "skid register empty".
REQ-014 SHALL keep out_imm, out_type, out_tag and out_illegal stable while out_valid && !out_ready.
REQ-015 SHALL deliver entries in acceptance order with no loss or duplication; a simultaneous accept and deliver SHALL keep occupancy unchanged.
REQ-016 SHALL decode as follows: LUI/AUIPC give U, {instr[31:12], 12'b0} sign-extended from bit 31 to XLEN; JAL gives J; STORE gives S; BRANCH gives B; LOAD, JALR and OP-IMM give I. All of these are sign-extended from instr[31].
REQ-017 For OP-IMM with funct3 001 or 101, SHALL output I with the shamt zero-extended: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-018 For SYSTEM with funct3 1-3, SHALL output I with instr[31:20] zero-extended; with funct3 5-7, SHALL output Z with instr[19:15] zero-extended.
REQ-019 For OP (0110011), MISC-MEM (0001111), SYSTEM funct3 0 and SYSTEM funct3 4, SHALL output NONE with imm 0 and illegal 0.
REQ-020 For any other opcode, or instr[1:0] != 2'b11, SHALL output NONE with imm 0 and illegal 1.
REQ-021 flush SHALL empty both entries at the next edge (out_valid=0, in_ready=1); an input offered in the flush cycle SHALL be dropped.
REQ-022 flush and out_ready asserted together SHALL not count as a delivery.

Reset
REQ-023 While rst is high, in_ready SHALL be 0; on the first cycle after rst falls, in_ready SHALL be 1.
REQ-024 rst SHALL clear out_valid and the skid register, and SHALL zero out_imm, out_type, out_tag and out_illegal.
REQ-025 rst asserted mid-transfer SHALL discard all held entries; rst SHALL take priority over flush and over any handshake.

Configuration
REQ-026 Macro IMMGEN_LEGACY_UEXT_EN defined: immediates for SLTIU, LBU and LHU and offsets for BLTU and BGEU SHALL be zero-extended, for compatibility with the existing datapath.
REQ-027 Macro IMMGEN_LEGACY_UEXT_EN undefined: those cases SHALL sign-extend as in REQ-016; no other behaviour changes.

Verification
REQ-028 addi x1,x0,-1 (0xFFF00093), XLEN=32, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_type=1, out_illegal=0.
REQ-029 bltu x0,x0,-4 (0xFE006EE3) -> out_imm=0xFFFFFFFC with the macro undefined; out_imm=0x00001FFC with it defined.
REQ-030 lui (0x800000B7), XLEN=64 -> out_imm=0xFFFFFFFF80000000, out_type=4; csrrwi (0x300FD073) -> out_imm=0x1F, out_type=6.
REQ-031 out_ready=0, three back-to-back inputs offered with tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 from the cycle after the second accept; on release, tags are delivered 1,2,3 in order.
REQ-032 Both entries full, flush pulsed for one cycle -> next cycle out_valid=0 and in_ready=1; a new input with tag 7 is delivered normally afterwards.
REQ-033 Input 0x00000000, then 0x0000007F -> both give out_illegal=1, out_type=0, out_imm=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator behind a two-entry skid pipeline.
// Each accepted instruction is decoded into a sign- or zero-extended immediate,
// an immediate type code and an illegal-encoding flag, then held in the output
// register (or the skid register under backpressure) until delivered.
// Optional feature macro: IMMGEN_LEGACY_UEXT_EN makes the SLTIU, LBU and LHU
// immediates and the BLTU and BGEU offsets zero-extended instead of sign-extended.
// XLEN may only be 32 or 64.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_kind_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       kind;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

`ifdef IMMGEN_LEGACY_UEXT_EN
    localparam bit LEGACY_UEXT = 1'b1;
`else
    localparam bit LEGACY_UEXT = 1'b0;
`endif

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] raw;
    logic [63:0] wide;
    logic        fill;
    logic        illegal;
    imm_kind_e   kind;
    entry_t      new_entry;
    entry_t      out_entry;
    entry_t      skid_entry;
    logic        skid_valid;
    logic        accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign accept = in_valid && in_ready;

    // Decode the incoming instruction; 'fill' is the bit replicated above each
    // immediate field, so it doubles as the sign for the XLEN extension.
    always_comb begin
        raw     = 32'b0;
        fill    = 1'b0;
        illegal = 1'b0;
        kind    = IMM_NONE;
        if (in_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                7'b0110111, 7'b0010111: begin
                    kind = IMM_U;
                    fill = in_instr[31];
                    raw  = {in_instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    kind = IMM_J;
                    fill = in_instr[31];
                    raw  = {{11{fill}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
                end
                7'b0100011: begin
                    kind = IMM_S;
                    fill = in_instr[31];
                    raw  = {{20{fill}}, in_instr[31:25], in_instr[11:7]};
                end
                7'b1100011: begin
                    kind = IMM_B;
                    fill = in_instr[31] & ~(LEGACY_UEXT & (funct3[2:1] == 2'b11));
                    raw  = {{19{fill}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
                end
                7'b0000011: begin
                    kind = IMM_I;
                    fill = in_instr[31] &
                           ~(LEGACY_UEXT & ((funct3 == 3'b100) || (funct3 == 3'b101)));
                    raw  = {{20{fill}}, in_instr[31:20]};
                end
                7'b1100111: begin
                    kind = IMM_I;
                    fill = in_instr[31];
                    raw  = {{20{fill}}, in_instr[31:20]};
                end
                7'b0010011: begin
                    kind = IMM_I;
                    if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                        raw = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
                    end else begin
                        fill = in_instr[31] & ~(LEGACY_UEXT & (funct3 == 3'b011));
                        raw  = {{20{fill}}, in_instr[31:20]};
                    end
                end
                7'b1110011: begin
                    case (funct3)
                        3'd1, 3'd2, 3'd3: begin
                            kind = IMM_I;
                            raw  = {20'b0, in_instr[31:20]};
                        end
                        3'd5, 3'd6, 3'd7: begin
                            kind = IMM_Z;
                            raw  = {27'b0, in_instr[19:15]};
                        end
                        default: kind = IMM_NONE;
                    endcase
                end
                7'b0110011, 7'b0001111: kind = IMM_NONE;
                default: illegal = 1'b1;
            endcase
        end
        wide              = {{32{fill}}, raw};
        new_entry.imm     = wide[XLEN-1:0];
        new_entry.kind    = kind;
        new_entry.tag     = in_tag;
        new_entry.illegal = illegal;
    end

    // Output register plus skid register; in_ready is registered and tracks an
    // empty skid slot, so an accept never coincides with a full skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_entry  <= '0;
            out_valid  <= 1'b0;
            skid_entry <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || out_ready) begin
            in_ready <= 1'b1;
            if (skid_valid) begin
                out_entry  <= skid_entry;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_entry <= new_entry;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_entry <= new_entry;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end else begin
            in_ready <= !skid_valid;
        end
    end

    assign out_imm     = out_entry.imm;
    assign out_type    = out_entry.kind;
    assign out_tag     = out_entry.tag;
    assign out_illegal = out_entry.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with identical
// stimulus and compares both against a queue-based reference model, a table of
// known encodings and hand-written handshake sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32;
    logic [2:0]  type32;
    logic [4:0]  tag32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64;
    logic [2:0]  type64;
    logic [4:0]  tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(type32), .out_tag(tag32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(type64), .out_tag(tag64), .out_illegal(ill64)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        int          kind;
        logic [4:0]  tag;
        bit          illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [63:0] imm64;
        int          kind;
        bit          illegal;
    } vec_t;

`ifdef IMMGEN_LEGACY_UEXT_EN
    localparam bit LEGACY = 1'b1;
`else
    localparam bit LEGACY = 1'b0;
`endif

    exp_t       q32[$];
    exp_t       q64[$];
    logic [4:0] delivered[$];
    vec_t       vecs[16];
    int         checks = 0;
    int         passes = 0;
    bit         started = 1'b0;
    bit         rst_last = 1'b1;
    bit         last_acc = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference decode: assemble the immediate as a number from its fields,
    // then apply two's-complement sign adjustment over the field width.
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit x64);
        exp_t   e;
        longint raw;
        int     w;
        bit     sgn;
        int     f3;
        f3 = int'(ins[14:12]);
        e.imm = '0; e.kind = 0; e.tag = '0; e.illegal = 1'b0;
        raw = 0; w = 12; sgn = 1'b0;
        if (ins[1:0] != 2'b11) begin
            e.illegal = 1'b1;
        end else begin
            case (ins[6:0])
                7'h37, 7'h17: begin
                    e.kind = 4; raw = longint'(ins[31:12]) * 4096; w = 32; sgn = 1'b1;
                end
                7'h6F: begin
                    e.kind = 5; w = 21; sgn = 1'b1;
                    raw = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                          longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                end
                7'h23: begin
                    e.kind = 2; sgn = 1'b1;
                    raw = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                end
                7'h63: begin
                    e.kind = 3; w = 13; sgn = !(LEGACY && (f3 == 6 || f3 == 7));
                    raw = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                          longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                end
                7'h03: begin
                    e.kind = 1; raw = longint'(ins[31:20]); sgn = !(LEGACY && (f3 == 4 || f3 == 5));
                end
                7'h67: begin
                    e.kind = 1; raw = longint'(ins[31:20]); sgn = 1'b1;
                end
                7'h13: begin
                    e.kind = 1;
                    if (f3 == 1 || f3 == 5) raw = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                    else begin
                        raw = longint'(ins[31:20]); sgn = !(LEGACY && f3 == 3);
                    end
                end
                7'h73: begin
                    if (f3 >= 1 && f3 <= 3) begin
                        e.kind = 1; raw = longint'(ins[31:20]);
                    end else if (f3 >= 5) begin
                        e.kind = 6; raw = longint'(ins[19:15]);
                    end
                end
                7'h33, 7'h0F: e.kind = 0;
                default: e.illegal = 1'b1;
            endcase
        end
        if (sgn && raw >= (longint'(1) << (w - 1))) raw = raw - (longint'(1) << w);
        e.imm = x64 ? 64'(raw) : {32'h0, raw[31:0]};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 11)]};
    endfunction

    // One clock: compare both DUTs with the model at the falling edge, then
    // advance the model on the rising edge and release inputs 1 time unit later.
    task automatic apply_stimulus();
        bit acc, del;
        exp_t e;
        @(negedge clk);
        if (started) begin
            if (rst_last) begin
                check_output("rst_in_ready32", rdy32, 0);
                check_output("rst_in_ready64", rdy64, 0);
                check_output("rst_out_valid32", ov32, 0);
                check_output("rst_out_imm32", imm32, 0);
                check_output("rst_out_type32", type32, 0);
                check_output("rst_out_tag32", tag32, 0);
                check_output("rst_out_illegal32", ill32, 0);
                check_output("rst_out_imm64", imm64, 0);
            end else begin
                check_output("in_ready32", rdy32, q32.size() < 2);
                check_output("in_ready64", rdy64, q64.size() < 2);
                check_output("out_valid32", ov32, q32.size() > 0);
                check_output("out_valid64", ov64, q64.size() > 0);
                if (q32.size() > 0) begin
                    check_output("out_imm32", imm32, q32[0].imm);
                    check_output("out_type32", type32, q32[0].kind);
                    check_output("out_tag32", tag32, q32[0].tag);
                    check_output("out_illegal32", ill32, q32[0].illegal);
                    check_output("out_imm64", imm64, q64[0].imm);
                    check_output("out_type64", type64, q64[0].kind);
                    check_output("out_tag64", tag64, q64[0].tag);
                    check_output("out_illegal64", ill64, q64[0].illegal);
                end
            end
        end
        acc = started && !rst_last && in_valid && (q32.size() < 2);
        del = started && !rst_last && out_ready && (q32.size() > 0);
        if (ov32 && out_ready && !rst && !flush) delivered.push_back(tag32);
        @(posedge clk);
        started  = 1'b1;
        rst_last = rst;
        last_acc = acc && !rst && !flush;
        if (rst || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (del) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (acc) begin
                e = ref_decode(in_instr, 1'b0); e.tag = in_tag; q32.push_back(e);
                e = ref_decode(in_instr, 1'b1); e.tag = in_tag; q64.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1'b0};
        vecs[1]  = LEGACY ? '{32'hFE006EE3, 32'h00001FFC, 64'h0000000000001FFC, 3, 1'b0}
                          : '{32'hFE006EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3, 1'b0};
        vecs[2]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 4, 1'b0};
        vecs[3]  = '{32'h300FD073, 32'h0000001F, 64'h000000000000001F, 6, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h00000000, 64'h0, 0, 1'b1};
        vecs[5]  = '{32'h0000007F, 32'h00000000, 64'h0, 0, 1'b1};
        vecs[6]  = '{32'hFE112C23, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 2, 1'b0};
        vecs[7]  = '{32'h001000EF, 32'h00000800, 64'h0000000000000800, 5, 1'b0};
        vecs[8]  = '{32'h41F0D093, 32'h0000001F, 64'h000000000000001F, 1, 1'b0};
        vecs[9]  = '{32'h03F09093, 32'h0000001F, 64'h000000000000003F, 1, 1'b0};
        vecs[10] = '{32'hFFF02073, 32'h00000FFF, 64'h0000000000000FFF, 1, 1'b0};
        vecs[11] = '{32'h002081B3, 32'h00000000, 64'h0, 0, 1'b0};
        vecs[12] = '{32'h0FF0000F, 32'h00000000, 64'h0, 0, 1'b0};
        vecs[13] = LEGACY ? '{32'hFFF04083, 32'h00000FFF, 64'h0000000000000FFF, 1, 1'b0}
                          : '{32'hFFF04083, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1'b0};
        vecs[14] = '{32'h00000073, 32'h00000000, 64'h0, 0, 1'b0};
        vecs[15] = '{32'h12345097, 32'h12345000, 64'h0000000012345000, 4, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        repeat (3) apply_stimulus();
        rst = 1'b0;
        apply_stimulus();
        check_output("in_ready_after_reset", rdy32, 1);

        // Known encodings, one at a time with no backpressure: 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_tag = 5'(i);
            apply_stimulus();
            in_valid = 1'b0;
            check_output($sformatf("vec%0d_valid", i), ov32, 1);
            check_output($sformatf("vec%0d_imm32", i), imm32, vecs[i].imm32);
            check_output($sformatf("vec%0d_imm64", i), imm64, vecs[i].imm64);
            check_output($sformatf("vec%0d_type", i), type32, vecs[i].kind);
            check_output($sformatf("vec%0d_illegal", i), ill32, vecs[i].illegal);
            apply_stimulus();
        end

        // Backpressure: three offers with tags 1,2,3, only two fit.
        out_ready = 1'b0; delivered.delete();
        for (int t = 1; t <= 3; t++) begin
            in_valid = 1'b1; in_instr = vecs[t].instr; in_tag = 5'(t);
            apply_stimulus();
        end
        check_output("bp_in_ready_full", rdy32, 0);
        check_output("bp_out_tag_held", tag32, 1);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && delivered.size() < 3; n++) begin
            apply_stimulus();
            if (last_acc && in_tag == 5'd3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check_output("bp_delivered_count", delivered.size(), 3);
        for (int i = 0; i < 3; i++)
            check_output($sformatf("bp_order%0d", i),
                         (i < delivered.size()) ? delivered[i] : 5'd0, i + 1);

        // Flush with both entries full; an offer during flush is dropped.
        out_ready = 1'b0;
        for (int t = 4; t <= 5; t++) begin
            in_valid = 1'b1; in_instr = vecs[t + 2].instr; in_tag = 5'(t);
            apply_stimulus();
        end
        in_tag = 5'd6; flush = 1'b1;
        apply_stimulus();
        flush = 1'b0; in_valid = 1'b0;
        check_output("flush_out_valid", ov32, 0);
        check_output("flush_in_ready", rdy32, 1);
        delivered.delete();
        in_valid = 1'b1; in_instr = vecs[7].instr; in_tag = 5'd7; out_ready = 1'b1;
        apply_stimulus();
        in_valid = 1'b0;
        repeat (3) apply_stimulus();
        check_output("flush_after_count", delivered.size(), 1);
        check_output("flush_after_tag", (delivered.size() > 0) ? delivered[0] : 5'd0, 7);

        // Reset mid-transfer wins over flush and discards held entries.
        out_ready = 1'b0;
        for (int t = 8; t <= 9; t++) begin
            in_valid = 1'b1; in_instr = vecs[t].instr; in_tag = 5'(t);
            apply_stimulus();
        end
        in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
        apply_stimulus();
        rst = 1'b0; flush = 1'b0;
        apply_stimulus();
        check_output("midrst_out_valid", ov32, 0);
        check_output("midrst_in_ready", rdy32, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rand_instr();
            in_tag    = 5'($urandom());
            apply_stimulus();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) apply_stimulus();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
